// File: rtl/clk_ctrl_pkg.sv
// Shared encodings for the CPU clock-enable controller: mode inputs and FSM state codes.
package clk_ctrl_pkg;

  localparam logic [1:0] MODE_RUN  = 2'b00;
  localparam logic [1:0] MODE_STEP = 2'b01;
  localparam logic [1:0] MODE_HALT = 2'b10;

  // Fixed codes so that the debug port decodes the same in every build.
  typedef enum logic [2:0] {
    HOLD      = 3'd0,
    RUN       = 3'd1,
    STEP_IDLE = 3'd2,
    STEP_RUN  = 3'd3,
    HALT      = 3'd4
  } state_t;

  // State entered at a decision point for a given mode request; 11 is treated as HALT.
  function automatic state_t mode_to_state(input logic [1:0] mode);
    state_t s;
    if (mode == MODE_RUN)       s = RUN;
    else if (mode == MODE_STEP) s = STEP_IDLE;
    else                        s = HALT;
    return s;
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchroniser followed by a registered rising-edge detector.
// The rise pulse is one clk wide and appears three clks after the input edge.
module sync_edge_det (
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic rise
);

  logic sync_1;
  logic sync_2;
  logic prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
      prev   <= 1'b0;
      rise   <= 1'b0;
    end else begin
      sync_1 <= level;
      sync_2 <= sync_1;
      prev   <= sync_2;
      rise   <= sync_2 & ~prev;
    end
  end

endmodule

// File: rtl/cpu_clk_enable_ctrl.sv
// CPU clock-enable generator: stretched core reset, en_a/en_b phase pulses,
// RUN/STEP/HALT sequencing and a retired-cycle counter, all on the single clk.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   HOLD      | cpu_rst asserted, counting out the reset stretch
//   RUN       | free-running CPU periods
//   STEP_IDLE | step mode, waiting for a synchronised step_req edge
//   STEP_RUN  | step mode, executing exactly one CPU period
//   HALT      | no periods, mode polled every clk
module cpu_clk_enable_ctrl
  import clk_ctrl_pkg::*;
#(
  parameter int DIV_W      = 8,
  parameter int RST_CYCLES = 16,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DIV_W-1:0] div,
  input  logic [1:0]       mode,
  input  logic             step_req,
  output logic             cpu_rst,
  output logic             en_a,
  output logic             en_b,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [2:0]       state_o
);

  localparam int CW     = DIV_W + 1;
  localparam int RCNT_W = $clog2(RST_CYCLES + 1);
  localparam logic [RCNT_W-1:0] RCNT_LAST = RCNT_W'(RST_CYCLES - 1);

  state_t            state;
  state_t            next_state;
  logic [CW-1:0]     cnt;
  logic [DIV_W-1:0]  div_q;
  logic [RCNT_W-1:0] rcnt;
  logic              pending;
  logic              pending_n;
  logic              step_rise;

  logic              active;
  logic              next_active;
  logic              rst_done;
  logic              period_end;
  logic              period_mid;
  logic              load;
  logic [CW-1:0]     cnt_last;
  logic [CW-1:0]     cnt_mid;

  sync_edge_det u_step_sync (
    .clk   (clk),
    .reset (reset),
    .level (step_req),
    .rise  (step_rise)
  );

  assign active      = (state == RUN) || (state == STEP_RUN);
  assign next_active = (next_state == RUN) || (next_state == STEP_RUN);
  assign cnt_last    = {div_q, 1'b1};
  assign cnt_mid     = {1'b0, div_q};
  assign period_end  = active && (cnt == cnt_last);
  assign period_mid  = active && (cnt == cnt_mid);
  assign rst_done    = (state == HOLD) && (rcnt == RCNT_LAST);

  // Idle states have no period in flight, so the one about to start may take a fresh div.
  assign load = rst_done || period_end || (!active && next_active);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= HOLD;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      HOLD:      if (rst_done) next_state = mode_to_state(mode);
      RUN,
      STEP_RUN:  if (period_end) next_state = mode_to_state(mode);
      STEP_IDLE: begin
        if (mode != MODE_STEP) next_state = mode_to_state(mode);
        else if (pending)      next_state = STEP_RUN;
      end
      HALT:      next_state = mode_to_state(mode);
      default:   next_state = HOLD;
    endcase
  end

  always_comb begin
    en_a    = period_end;
    en_b    = period_mid;
    state_o = state;
  end

  // One request may be queued; leaving step mode discards it.
  always_comb begin
    pending_n = 1'b0;
    if ((next_state == STEP_IDLE) || (next_state == STEP_RUN)) begin
      if ((state == STEP_IDLE) && (next_state == STEP_RUN)) pending_n = step_rise;
      else                                                   pending_n = pending | step_rise;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt     <= '0;
      div_q   <= '0;
      rcnt    <= '0;
      pending <= 1'b0;
      cpu_rst <= 1'b1;
    end else begin
      if (state == HOLD) rcnt <= rcnt + RCNT_W'(1);

      if (load) begin
        cnt   <= '0;
        div_q <= div;
      end else if (active) begin
        cnt <= cnt + CW'(1);
      end else begin
        cnt <= '0;
      end

      pending <= pending_n;
      cpu_rst <= (next_state == HOLD);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)     cycle_cnt <= '0;
    else if (en_a) cycle_cnt <= cycle_cnt + CNT_W'(1);
  end

endmodule

// File: tb/tb_cpu_clk_enable_ctrl.sv
// Directed bench for cpu_clk_enable_ctrl; a narrow-counter second instance covers cycle_cnt wrap.
module tb_cpu_clk_enable_ctrl;
  import clk_ctrl_pkg::*;

  logic        clk      = 1'b0;
  logic        reset    = 1'b1;
  logic        step_req = 1'b0;
  logic [7:0]  div      = 8'd7;
  logic [1:0]  mode     = MODE_RUN;
  logic        cpu_rst;
  logic        en_a;
  logic        en_b;
  logic [31:0] cycle_cnt;
  logic [2:0]  state_o;

  logic        reset_w  = 1'b1;
  logic        cpu_rst_w;
  logic        en_a_w;
  logic        en_b_w;
  logic [3:0]  cycle_cnt_w;
  logic [2:0]  state_o_w;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  cpu_clk_enable_ctrl #(.DIV_W(8), .RST_CYCLES(16), .CNT_W(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .div       (div),
    .mode      (mode),
    .step_req  (step_req),
    .cpu_rst   (cpu_rst),
    .en_a      (en_a),
    .en_b      (en_b),
    .cycle_cnt (cycle_cnt),
    .state_o   (state_o)
  );

  cpu_clk_enable_ctrl #(.DIV_W(8), .RST_CYCLES(2), .CNT_W(4)) dut_w (
    .clk       (clk),
    .reset     (reset_w),
    .div       (8'd0),
    .mode      (MODE_RUN),
    .step_req  (1'b0),
    .cpu_rst   (cpu_rst_w),
    .en_a      (en_a_w),
    .en_b      (en_b_w),
    .cycle_cnt (cycle_cnt_w),
    .state_o   (state_o_w)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_pulse(input bit on_a, input int budget, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(on_a ? en_a : en_b) && n < budget);
    check(on_a ? "en_a_seen" : "en_b_seen", 64'(on_a ? en_a : en_b), 64'd1);
  endtask

  task automatic count_pulses(input int cycles, output int na, output int nb);
    na = 0;
    nb = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (en_a) na++;
      if (en_b) nb++;
    end
  endtask

  // Enables must never overlap each other or the core reset.
  always @(negedge clk)
    check("en_excl", 64'({en_a & en_b, (en_a | en_b) & cpu_rst}), 64'd0);

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, na, nb, ta, tb;

    // Reset state and 16-cycle stretch, RUN with div=7 (P=16).
    repeat (3) @(negedge clk);
    check("rst_cpu_rst", 64'(cpu_rst), 64'd1);
    check("rst_en_a", 64'(en_a), 64'd0);
    check("rst_en_b", 64'(en_b), 64'd0);
    check("rst_cycle_cnt", 64'(cycle_cnt), 64'd0);
    check("rst_state", 64'(state_o), 64'(HOLD));
    reset = 1'b0;
    repeat (15) @(negedge clk);
    check("stretch_edge15", 64'(cpu_rst), 64'd1);
    check("stretch_state15", 64'(state_o), 64'(HOLD));
    @(negedge clk);
    check("stretch_edge16", 64'(cpu_rst), 64'd0);
    check("run_state", 64'(state_o), 64'(RUN));
    // cnt=0 now; en_b at cnt 7, en_a at cnt 15
    wait_pulse(1'b0, 40, n); check("first_en_b", 64'(n), 64'd7);
    wait_pulse(1'b1, 40, n); check("first_en_a", 64'(n), 64'd8);
    @(negedge clk);
    check("cycle_cnt_1", 64'(cycle_cnt), 64'd1);
    wait_pulse(1'b0, 40, n); check("p2_en_b", 64'(n), 64'd7);
    wait_pulse(1'b1, 40, n); check("p2_en_a", 64'(n), 64'd8);

    // div 7 -> 1 at cnt=3: this period stays 16, the next is 4.
    repeat (4) @(negedge clk);
    div = 8'd1;
    wait_pulse(1'b0, 40, n); check("divchg_en_b", 64'(n), 64'd4);
    wait_pulse(1'b1, 40, n); check("divchg_en_a", 64'(n), 64'd8);
    wait_pulse(1'b0, 40, n); check("div1_en_b", 64'(n), 64'd2);
    wait_pulse(1'b1, 40, n); check("div1_en_a", 64'(n), 64'd2);
    wait_pulse(1'b1, 40, n); check("div1_period", 64'(n), 64'd4);
    check("cycle_cnt_4", 64'(cycle_cnt), 64'd4);

    // HALT requested at cnt=3 of a 16-clk period: period completes, then silence.
    div = 8'd7;
    repeat (4) @(negedge clk);
    mode = MODE_HALT;
    wait_pulse(1'b1, 40, n); check("halt_finish_en_a", 64'(n), 64'd12);
    @(negedge clk);
    check("halt_state", 64'(state_o), 64'(HALT));
    check("halt_cycle_cnt", 64'(cycle_cnt), 64'd6);
    count_pulses(40, na, nb);
    check("halt_no_en_a", 64'(na), 64'd0);
    check("halt_no_en_b", 64'(nb), 64'd0);
    check("halt_frozen", 64'(cycle_cnt), 64'd6);
    mode = MODE_RUN;
    wait_pulse(1'b0, 40, n); check("resume_en_b", 64'(n), 64'd8);
    wait_pulse(1'b1, 40, n); check("resume_en_a", 64'(n), 64'd8);
    check("resume_cycle_cnt", 64'(cycle_cnt), 64'd6);

    // STEP mode, div=3 (P=8).
    div  = 8'd3;
    mode = MODE_STEP;
    @(negedge clk);
    check("step_idle_state", 64'(state_o), 64'(STEP_IDLE));
    check("step_idle_cnt", 64'(cycle_cnt), 64'd7);
    count_pulses(10, na, nb);
    check("step_idle_quiet", 64'(na + nb), 64'd0);
    // three rising edges inside one clk period
    step_req = 1'b1; #1 step_req = 1'b0; #1 step_req = 1'b1; #1 step_req = 1'b0; #1 step_req = 1'b1;
    wait_pulse(1'b0, 30, n);
    wait_pulse(1'b1, 30, n); check("step_b_to_a", 64'(n), 64'd4);
    count_pulses(20, na, nb);
    check("burst_single_a", 64'(na), 64'd0);
    check("burst_single_b", 64'(nb), 64'd0);
    check("burst_cycle_cnt", 64'(cycle_cnt), 64'd8);
    step_req = 1'b0;
    repeat (5) @(negedge clk);

    ta = 0;
    tb = 0;
    for (int i = 0; i < 2; i++) begin
      step_req = 1'b1;
      count_pulses(10, na, nb); ta += na; tb += nb;
      step_req = 1'b0;
      count_pulses(10, na, nb); ta += na; tb += nb;
    end
    check("spaced_en_a", 64'(ta), 64'd2);
    check("spaced_en_b", 64'(tb), 64'd2);
    check("spaced_cycle_cnt", 64'(cycle_cnt), 64'd10);

    // second edge lands while the first period is still running
    step_req = 1'b1;
    repeat (3) @(negedge clk);
    step_req = 1'b0;
    repeat (3) @(negedge clk);
    step_req = 1'b1;
    count_pulses(40, na, nb);
    check("queued_en_a", 64'(na + 0), 64'd2);
    check("queued_en_b", 64'(nb), 64'd2);
    check("queued_cycle_cnt", 64'(cycle_cnt), 64'd12);
    step_req = 1'b0;

    // Back to RUN with div=7, then reset at cnt=5 before en_b.
    div  = 8'd7;
    mode = MODE_RUN;
    wait_pulse(1'b1, 60, n);
    repeat (6) @(negedge clk);
    check("pre_reset_en_b", 64'(en_b), 64'd0);
    #2 reset = 1'b1;
    #1;
    check("async_cpu_rst", 64'(cpu_rst), 64'd1);
    check("async_en_a", 64'(en_a), 64'd0);
    check("async_en_b", 64'(en_b), 64'd0);
    check("async_cycle_cnt", 64'(cycle_cnt), 64'd0);
    check("async_state", 64'(state_o), 64'(HOLD));
    div = 8'd0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (15) @(negedge clk);
    check("restretch_edge15", 64'(cpu_rst), 64'd1);
    @(negedge clk);
    check("restretch_edge16", 64'(cpu_rst), 64'd0);

    // div=0: en_b at cnt 0, en_a at cnt 1, alternating every clk.
    check("div0_first_b", 64'({en_b, en_a}), 64'b10);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("div0_a", 64'({en_b, en_a}), 64'b01);
      @(negedge clk);
      check("div0_b", 64'({en_b, en_a}), 64'b10);
    end
    check("div0_cycle_cnt", 64'(cycle_cnt), 64'd4);

    // 4-bit counter instance: 15 -> 0 on the next en_a.
    reset_w = 1'b0;
    n = 0;
    while (cycle_cnt_w != 4'd15 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("wrap_reach_max", 64'(cycle_cnt_w), 64'd15);
    while (!en_a_w && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("wrap_en_a", 64'(en_a_w), 64'd1);
    @(negedge clk);
    check("wrap_zero", 64'(cycle_cnt_w), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
